// File: rtl/plc_io_scan_dma_if.sv
// Scan-engine control and image-memory port bundle; suffixes are from the engine's side.
// master = scan engine, slave = CPU/memory side driving start/mode/hold and read data.
interface plc_io_scan_dma_if #(
    parameter int AW = 5
);
    logic          start_i;
    logic [1:0]    mode_i;
    logic          hold_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] mem_a_o;
    logic          mem_di_o;
    logic          mem_we_o;
    logic          mem_dq_i;

    modport master (
        input  start_i, mode_i, hold_i, mem_dq_i,
        output busy_o, done_o, mem_a_o, mem_di_o, mem_we_o
    );

    modport slave (
        output start_i, mode_i, hold_i, mem_dq_i,
        input  busy_o, done_o, mem_a_o, mem_di_o, mem_we_o
    );
endinterface

// File: rtl/plc_io_scan_dma.sv
// PLC I/O scan engine: snapshots inputs into image memory, reads outputs back, commits them atomically.
// Latency (no hold): mode 11 N_IN+N_OUT+2, mode 01 N_IN+1, mode 10 N_OUT+2, mode 00 1 cycle.
// Backpressure: hold_i stalls the write/read sequencer one cycle per asserted cycle; start ignored while busy.
module plc_io_scan_dma #(
    parameter int N_IN     = 16,
    parameter int N_OUT    = 16,
    parameter int AW       = 5,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    plc_io_scan_dma_if.master    bus,
    input  logic [N_IN-1:0]      in_i,
    output logic [N_OUT-1:0]     out_o
);
    localparam int NMAX = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam logic [CW-1:0] IN_LAST    = CW'(N_IN - 1);
    localparam logic [CW-1:0] OUT_LAST   = CW'(N_OUT - 1);
    localparam logic [AW-1:0] IN_BASE_A  = AW'(IN_BASE);
    localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IN_SCAN,
        S_OUT_RD,
        S_OUT_DRAIN,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      k_q, k_d;
    logic               do_out_q, do_out_d;
    logic [N_IN-1:0]    snap_q, snap_d;
    logic [N_OUT-1:0]   shadow_q, shadow_d;
    logic [N_OUT-1:0]   out_q, out_d;
    logic               rd_pend_q, rd_pend_d;
    logic [CW-1:0]      rd_idx_q, rd_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            do_out_q  <= 1'b0;
            snap_q    <= '0;
            shadow_q  <= '0;
            out_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            do_out_q  <= do_out_d;
            snap_q    <= snap_d;
            shadow_q  <= shadow_d;
            out_q     <= out_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        do_out_d  = do_out_q;
        snap_d    = snap_q;
        shadow_d  = shadow_q;
        out_d     = out_q;
        rd_pend_d = 1'b0;
        rd_idx_d  = rd_idx_q;

        // A read issued last cycle always lands, regardless of hold this cycle.
        if (rd_pend_q) begin
            shadow_d[rd_idx_q] = bus.mem_dq_i;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    do_out_d = bus.mode_i[1];
                    snap_d   = in_i;
                    k_d      = '0;
                    case (bus.mode_i)
                        2'b00:   state_d = S_FIN;
                        2'b10:   state_d = S_OUT_RD;
                        default: state_d = S_IN_SCAN;
                    endcase
                end
            end
            S_IN_SCAN: begin
                if (!bus.hold_i) begin
                    if (k_q == IN_LAST) begin
                        k_d     = '0;
                        state_d = do_out_q ? S_OUT_RD : S_FIN;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            S_OUT_RD: begin
                if (!bus.hold_i) begin
                    rd_pend_d = 1'b1;
                    rd_idx_d  = k_q;
                    if (k_q == OUT_LAST) begin
                        k_d     = '0;
                        state_d = S_OUT_DRAIN;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            S_OUT_DRAIN: begin
                // shadow_d already holds the final bit, so every output flips on this one edge.
                out_d   = shadow_d;
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_a_o  = '0;
        bus.mem_di_o = 1'b0;
        bus.mem_we_o = 1'b0;
        case (state_q)
            S_IN_SCAN: begin
                bus.mem_a_o  = IN_BASE_A + AW'(k_q);
                bus.mem_di_o = snap_q[k_q];
                bus.mem_we_o = ~bus.hold_i;
            end
            S_OUT_RD: begin
                bus.mem_a_o = OUT_BASE_A + AW'(k_q);
            end
            default: ;
        endcase
    end

    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.done_o = (state_q == S_FIN);
    assign out_o      = out_q;
endmodule

// File: tb/tb_plc_io_scan_dma.sv
// Randomised bench for plc_io_scan_dma with a 1-bit image memory model and a scan-level reference model.
`timescale 1ns/1ps
module tb_plc_io_scan_dma;
    localparam int N_IN     = 16;
    localparam int N_OUT    = 16;
    localparam int AW       = 5;
    localparam int IN_BASE  = 0;
    localparam int OUT_BASE = 16;
    localparam int MSZ      = 1 << AW;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [N_IN-1:0]    in_v;
    logic [N_OUT-1:0]   out_v;

    plc_io_scan_dma_if #(.AW(AW)) bus();

    plc_io_scan_dma #(
        .N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .in_i  (in_v),
        .out_o (out_v)
    );

    always #5 clk = ~clk;

    logic [MSZ-1:0] mem_q;
    logic           pl_we;
    logic [MSZ-1:0] pl_dat;

    always @(posedge clk) begin
        if (pl_we) mem_q <= pl_dat;
        else if (bus.mem_we_o) mem_q[bus.mem_a_o] <= bus.mem_di_o;
        bus.mem_dq_i <= mem_q[bus.mem_a_o];
    end

    int vectors = 0;
    int miscompares = 0;
    logic [N_OUT-1:0] model_out = '0;

    task automatic preload(input logic [MSZ-1:0] v);
        pl_dat = v;
        pl_we  = 1'b1;
        @(posedge clk); #1;
        pl_we  = 1'b0;
    endtask

    // hold_style: 0 none, 1 random, 2 three cycles in input phase and two in output phase
    task automatic run_scan(input logic [1:0] m, input logic [N_IN-1:0] inv, input int hold_style,
                            input int restart_cyc, input int abort_cyc);
        int work, tail, rem, last_work, wr_idx;
        logic [MSZ-1:0]   exp_mem;
        logic [N_OUT-1:0] exp_out, old_out;
        logic [N_IN-1:0]  snap;
        logic             exp_done;
        snap      = inv;
        work      = (m[0] ? N_IN : 0) + (m[1] ? N_OUT : 0);
        tail      = m[1] ? 2 : 1;
        rem       = work;
        last_work = 0;
        wr_idx    = 0;
        exp_mem   = mem_q;
        if (m[0]) for (int i = 0; i < N_IN; i++) exp_mem[(IN_BASE + i) % MSZ] = snap[i];
        old_out = model_out;
        exp_out = model_out;
        if (m[1]) for (int i = 0; i < N_OUT; i++) exp_out[i] = exp_mem[(OUT_BASE + i) % MSZ];

        bus.start_i = 1'b1;
        bus.mode_i  = m;
        in_v        = inv;
        @(posedge clk); #1;
        for (int c = 1; c <= work + tail + 64; c++) begin
            bus.start_i = (c == restart_cyc);
            in_v = (c == 5) ? '0 : N_IN'($urandom);
            if (rem > 0) begin
                case (hold_style)
                    1:       bus.hold_i = ($urandom_range(0, 2) == 0);
                    2:       bus.hold_i = (c inside {5, 6, 7, 22, 23});
                    default: bus.hold_i = 1'b0;
                endcase
            end else begin
                bus.hold_i = (hold_style == 1) ? 1'($urandom) : 1'b0;
            end
            if (rem > 0 && !bus.hold_i) begin
                rem--;
                if (rem == 0) last_work = c;
            end
            if (c == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                vectors++;
                if (out_v !== '0) begin miscompares++; $display("FAIL abort_out c=%0d got %h exp 0", c, out_v); end
                vectors++;
                if ({bus.busy_o, bus.done_o, bus.mem_we_o} !== 3'b000) begin
                    miscompares++; $display("FAIL abort_ctl c=%0d busy/done/we got %b exp 000", c, {bus.busy_o, bus.done_o, bus.mem_we_o});
                end
                model_out   = '0;
                bus.hold_i  = 1'b0;
                bus.start_i = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            exp_done = (rem == 0) && (c == last_work + tail);
            vectors++;
            if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL busy c=%0d mode=%b got %b exp 1", c, m, bus.busy_o); end
            vectors++;
            if (bus.done_o !== exp_done) begin miscompares++; $display("FAIL done c=%0d mode=%b got %b exp %b", c, m, bus.done_o, exp_done); end
            vectors++;
            if (out_v !== (exp_done ? exp_out : old_out)) begin
                miscompares++; $display("FAIL out c=%0d mode=%b got %h exp %h", c, m, out_v, exp_done ? exp_out : old_out);
            end
            if (bus.mem_we_o === 1'b1) begin
                vectors++;
                if (bus.hold_i !== 1'b0) begin miscompares++; $display("FAIL we_in_hold c=%0d got we=1 exp we=0", c); end
                vectors++;
                if (!m[0] || wr_idx >= N_IN) begin
                    miscompares++; $display("FAIL extra_write c=%0d addr=%0d got we=1 exp we=0", c, bus.mem_a_o);
                end else if (bus.mem_a_o !== AW'((IN_BASE + wr_idx) % MSZ) || bus.mem_di_o !== snap[wr_idx]) begin
                    miscompares++; $display("FAIL write c=%0d got a=%0d d=%b exp a=%0d d=%b", c, bus.mem_a_o, bus.mem_di_o, (IN_BASE + wr_idx) % MSZ, snap[wr_idx]);
                end
                wr_idx++;
            end
            if (exp_done) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.hold_i  = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy_o, bus.done_o, bus.mem_we_o} !== 3'b000) begin
            miscompares++; $display("FAIL post_idle mode=%b busy/done/we got %b exp 000", m, {bus.busy_o, bus.done_o, bus.mem_we_o});
        end
        vectors++;
        if (wr_idx != (m[0] ? N_IN : 0)) begin miscompares++; $display("FAIL write_count mode=%b got %0d exp %0d", m, wr_idx, m[0] ? N_IN : 0); end
        vectors++;
        if (mem_q !== exp_mem) begin miscompares++; $display("FAIL image mode=%b got %h exp %h", m, mem_q, exp_mem); end
        model_out = exp_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.busy_o, bus.done_o, bus.mem_we_o, bus.mem_di_o} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_ctl busy/done/we/di got %b exp 0000", {bus.busy_o, bus.done_o, bus.mem_we_o, bus.mem_di_o});
        end
        vectors++;
        if (bus.mem_a_o !== '0) begin miscompares++; $display("FAIL reset_addr got %0d exp 0", bus.mem_a_o); end
        vectors++;
        if (out_v !== '0) begin miscompares++; $display("FAIL reset_out got %h exp 0", out_v); end
        @(posedge clk); #1 rst_n = 1'b1;
        preload({$urandom, $urandom});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.busy_o, bus.done_o, bus.mem_we_o} !== 3'b000 || out_v !== '0) begin
                miscompares++; $display("FAIL idle_after_reset cyc=%0d busy/done/we got %b out %h exp 000 out 0", i, {bus.busy_o, bus.done_o, bus.mem_we_o}, out_v);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_input_only();
        run_scan(2'b01, 16'h0F0F, 0, 0, 0);
    endtask

    task automatic test_output_only();
        preload({16'hA5C3, 16'($urandom)});
        run_scan(2'b10, 16'($urandom), 0, 0, 0);
        vectors++;
        if (model_out !== 16'hA5C3 || out_v !== 16'hA5C3) begin
            miscompares++; $display("FAIL out_only_value got %h exp a5c3", out_v);
        end
    endtask

    task automatic test_hold();
        preload({$urandom, $urandom});
        run_scan(2'b11, 16'hFFFF, 2, 0, 0);
    endtask

    task automatic test_coherency();
        run_scan(2'b11, 16'($urandom), 0, 10, 0);
    endtask

    task automatic test_reset_mid_scan();
        preload({16'h5A3C, 16'($urandom)});
        run_scan(2'b10, 16'($urandom), 0, 0, 0);
        run_scan(2'b11, 16'($urandom), 0, 0, 25);
        run_scan(2'b00, 16'($urandom), 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        bus.mode_i  = 2'b00;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.done_o !== 1'(c % 2) || bus.busy_o !== 1'(c % 2)) begin
                miscompares++; $display("FAIL back_to_back c=%0d done/busy got %b%b exp %0d%0d", c, bus.done_o, bus.busy_o, c % 2, c % 2);
            end
            @(posedge clk); #1;
        end
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) preload({$urandom, $urandom});
            run_scan(2'($urandom), 16'($urandom), 1, $urandom_range(0, 30), 0);
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.mode_i  = 2'b00;
        bus.hold_i  = 1'b0;
        in_v        = '0;
        pl_we       = 1'b0;
        pl_dat      = '0;
        test_reset();
        test_input_only();
        test_output_only();
        test_hold();
        test_coherency();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
